// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the 5-stage pipeline control: forward selects, execute FSM
// states and the per-stage destination shadow record.
package pipe_ctrl_pkg;

    // Widest register address a shadow record can hold; narrower addresses are zero-extended.
    localparam int unsigned AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_WB = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        EX_IDLE  = 1'b0,
        EX_MULTI = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic              valid;
        logic [AW_MAX-1:0] dst;
        logic              wr_en;
        logic              is_load;
    } stage_info_t;

    // A stage can supply a forwarded value if it writes a register; load data is
    // only available once the load has reached WB.
    function automatic logic fwd_source(input stage_info_t s, input logic allow_load);
        return s.valid && s.wr_en && (allow_load || !s.is_load);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forward-select for one E operand: compares the operand against the M and WB
// shadows, M taking priority over WB.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4
) (
    input  logic [ADDRESSWIDTH-1:0] src_addr_i,
    input  logic                    src_used_i,
    input  stage_info_t             m_info_i,
    input  stage_info_t             wb_info_i,
    output fwd_sel_e                sel_o
);

    logic [AW_MAX-1:0] src_ext;
    logic              m_hit;
    logic              wb_hit;

    assign src_ext = AW_MAX'(src_addr_i);

    assign m_hit  = src_used_i && fwd_source(m_info_i, 1'b0)  && (m_info_i.dst  == src_ext);
    assign wb_hit = src_used_i && fwd_source(wb_info_i, 1'b1) && (wb_info_i.dst == src_ext);

    always_comb begin
        sel_o = FWD_RF;
        if (m_hit) begin
            sel_o = FWD_M;
        end else if (wb_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward control for the F/D/E/M/WB core with multi-cycle execute ops.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDRESSWIDTH = 4,
    parameter int NSRC         = 2,
    parameter int EX_LAT       = 3,
    parameter int CNTWIDTH     = 32
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         dec_valid_i,
    input  logic [NSRC*ADDRESSWIDTH-1:0] dec_src_addr_i,
    input  logic [NSRC-1:0]              dec_src_used_i,
    input  logic [ADDRESSWIDTH-1:0]      dec_dst_addr_i,
    input  logic                         dec_wr_en_i,
    input  logic                         dec_is_load_i,
    input  logic                         dec_is_multi_i,
    input  logic                         ex_branch_taken_i,
    output logic                         stall_f_o,
    output logic                         stall_d_o,
    output logic                         flush_d_o,
    output logic                         flush_e_o,
    output logic                         ex_hold_o,
    output logic [2*NSRC-1:0]            fwd_sel_o,
    output logic [CNTWIDTH-1:0]          perf_stall_cnt_o,
    output logic [CNTWIDTH-1:0]          perf_flush_cnt_o
);

    localparam int unsigned LATW = (EX_LAT > 1) ? $clog2(EX_LAT) : 1;

    stage_info_t                  e_q, e_d;
    stage_info_t                  m_q, m_d;
    stage_info_t                  wb_q, wb_d;
    logic [NSRC*ADDRESSWIDTH-1:0] e_src_q, e_src_d;
    logic [NSRC-1:0]              e_used_q, e_used_d;

    ex_state_e                    state_q;
    logic [LATW-1:0]              cnt_q;
    logic                         hold_q;

    logic                         run;
    logic [NSRC-1:0]              lu_hit;
    logic                         lu_raw;
    logic                         br_raw;
    logic                         flush_e_raw;
    logic                         load_use;
    logic                         branch_flush;
    logic                         multi_start;
    fwd_sel_e                     sel_w [NSRC];

    assign run = !reset_i;

    for (genvar g = 0; g < NSRC; g++) begin : g_lu
        assign lu_hit[g] = dec_src_used_i[g]
                        && (e_q.dst == AW_MAX'(dec_src_addr_i[g*ADDRESSWIDTH +: ADDRESSWIDTH]));
    end

    // Hazard detection; a held E suppresses both load-use and branch action.
    assign lu_raw       = dec_valid_i && e_q.valid && e_q.is_load && e_q.wr_en
                       && (|lu_hit) && !hold_q;
    assign br_raw       = ex_branch_taken_i && e_q.valid && !hold_q;
    assign flush_e_raw  = lu_raw || br_raw;
    assign branch_flush = run && br_raw;
    assign load_use     = run && lu_raw && !br_raw;
    assign multi_start  = (EX_LAT > 1) && !hold_q && !flush_e_raw
                       && dec_valid_i && dec_is_multi_i;

    assign stall_f_o = load_use || (run && hold_q);
    assign stall_d_o = load_use || (run && hold_q);
    assign flush_d_o = branch_flush;
    assign flush_e_o = branch_flush || load_use;
    assign ex_hold_o = run && hold_q;

    for (genvar g = 0; g < NSRC; g++) begin : g_fwd
        fwd_select #(
            .ADDRESSWIDTH(ADDRESSWIDTH)
        ) u_fwd_select (
            .src_addr_i (e_src_q[g*ADDRESSWIDTH +: ADDRESSWIDTH]),
            .src_used_i (e_used_q[g]),
            .m_info_i   (m_q),
            .wb_info_i  (wb_q),
            .sel_o      (sel_w[g])
        );
        assign fwd_sel_o[2*g +: 2] = run ? sel_w[g] : FWD_RF;
    end

    always_comb begin
        e_d      = e_q;
        e_src_d  = e_src_q;
        e_used_d = e_used_q;
        m_d      = m_q;
        wb_d     = wb_q;
        if (hold_q) begin
            m_d  = '0;
            wb_d = m_q;
        end else begin
            m_d  = e_q;
            wb_d = m_q;
            if (flush_e_raw) begin
                e_d      = '0;
                e_src_d  = '0;
                e_used_d = '0;
            end else begin
                e_d.valid   = dec_valid_i;
                e_d.dst     = AW_MAX'(dec_dst_addr_i);
                e_d.wr_en   = dec_wr_en_i;
                e_d.is_load = dec_is_load_i;
                e_src_d     = dec_src_addr_i;
                e_used_d    = dec_src_used_i & {NSRC{dec_valid_i}};
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            e_q      <= '0;
            m_q      <= '0;
            wb_q     <= '0;
            e_src_q  <= '0;
            e_used_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            wb_q     <= wb_d;
            e_src_q  <= e_src_d;
            e_used_q <= e_used_d;
        end
    end

    // Execute FSM: hold_q stays high for EX_LAT-1 cycles after a multi op enters E.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= EX_IDLE;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
        end else begin
            case (state_q)
                EX_IDLE: begin
                    if (multi_start) begin
                        state_q <= EX_MULTI;
                        cnt_q   <= LATW'(EX_LAT - 1);
                        hold_q  <= 1'b1;
                    end
                end
                EX_MULTI: begin
                    cnt_q <= cnt_q - LATW'(1);
                    if (cnt_q <= LATW'(1)) begin
                        state_q <= EX_IDLE;
                        cnt_q   <= '0;
                        hold_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EX_IDLE;
                    cnt_q   <= '0;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNTWIDTH-1:0] stall_cnt_q;
    logic [CNTWIDTH-1:0] flush_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d_o && (stall_cnt_q != {CNTWIDTH{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNTWIDTH'(1);
            end
            if (flush_d_o && (flush_cnt_q != {CNTWIDTH{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNTWIDTH'(1);
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each step drives the D-stage inputs and
// queues the outputs expected in that cycle; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int AW     = 4;
    localparam int NSRC   = 2;
    localparam int EX_LAT = 3;
    localparam int CW     = 32;

    logic                 clock;
    logic                 reset;
    logic                 dec_valid;
    logic [NSRC*AW-1:0]   dec_src_addr;
    logic [NSRC-1:0]      dec_src_used;
    logic [AW-1:0]        dec_dst_addr;
    logic                 dec_wr_en;
    logic                 dec_is_load;
    logic                 dec_is_multi;
    logic                 ex_branch_taken;
    logic                 stall_f;
    logic                 stall_d;
    logic                 flush_d;
    logic                 flush_e;
    logic                 ex_hold;
    logic [2*NSRC-1:0]    fwd_sel;
    logic [CW-1:0]        perf_stall_cnt;
    logic [CW-1:0]        perf_flush_cnt;

    typedef struct {
        int          step;
        logic        sf;
        logic        sd;
        logic        fd;
        logic        fe;
        logic        hold;
        logic [3:0]  fwd;
        logic [31:0] pst;
        logic [31:0] pfl;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    pipe_hazard_ctrl #(
        .ADDRESSWIDTH(AW),
        .NSRC        (NSRC),
        .EX_LAT      (EX_LAT),
        .CNTWIDTH    (CW)
    ) dut (
        .clock_i          (clock),
        .reset_i          (reset),
        .dec_valid_i      (dec_valid),
        .dec_src_addr_i   (dec_src_addr),
        .dec_src_used_i   (dec_src_used),
        .dec_dst_addr_i   (dec_dst_addr),
        .dec_wr_en_i      (dec_wr_en),
        .dec_is_load_i    (dec_is_load),
        .dec_is_multi_i   (dec_is_multi),
        .ex_branch_taken_i(ex_branch_taken),
        .stall_f_o        (stall_f),
        .stall_d_o        (stall_d),
        .flush_d_o        (flush_d),
        .flush_e_o        (flush_e),
        .ex_hold_o        (ex_hold),
        .fwd_sel_o        (fwd_sel),
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_flush_cnt_o (perf_flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pc(input int n);
`ifdef PIPE_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    // ctl = {stall_f, stall_d, flush_d, flush_e, ex_hold}
    task automatic step(input logic rst, input logic v, input logic [3:0] s1, input logic [3:0] s0,
                        input logic [1:0] u, input logic [3:0] d, input logic w, input logic l,
                        input logic m, input logic b, input logic [4:0] ctl, input logic [3:0] fw,
                        input int ps, input int pf);
        exp_t e;
        @(posedge clock);
        #1;
        reset           = rst;
        dec_valid       = v;
        dec_src_addr    = {s1, s0};
        dec_src_used    = u;
        dec_dst_addr    = d;
        dec_wr_en       = w;
        dec_is_load     = l;
        dec_is_multi    = m;
        ex_branch_taken = b;
        e.step = step_no;
        e.sf   = ctl[4];
        e.sd   = ctl[3];
        e.fd   = ctl[2];
        e.fe   = ctl[1];
        e.hold = ctl[0];
        e.fwd  = fw;
        e.pst  = pc(ps);
        e.pfl  = pc(pf);
        exp_q.push_back(e);
        step_no++;
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("s%0d_stall_f", e.step), 32'(stall_f), 32'(e.sf));
            chk($sformatf("s%0d_stall_d", e.step), 32'(stall_d), 32'(e.sd));
            chk($sformatf("s%0d_flush_d", e.step), 32'(flush_d), 32'(e.fd));
            chk($sformatf("s%0d_flush_e", e.step), 32'(flush_e), 32'(e.fe));
            chk($sformatf("s%0d_ex_hold", e.step), 32'(ex_hold), 32'(e.hold));
            chk($sformatf("s%0d_fwd_sel", e.step), 32'(fwd_sel), 32'(e.fwd));
            chk($sformatf("s%0d_perf_stall", e.step), perf_stall_cnt, e.pst);
            chk($sformatf("s%0d_perf_flush", e.step), perf_flush_cnt, e.pfl);
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run exceeded 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset           = 1'b1;
        dec_valid       = 1'b0;
        dec_src_addr    = '0;
        dec_src_used    = '0;
        dec_dst_addr    = '0;
        dec_wr_en       = 1'b0;
        dec_is_load     = 1'b0;
        dec_is_multi    = 1'b0;
        ex_branch_taken = 1'b0;
        repeat (2) @(posedge clock);

        //    rst v  s1 s0 used  dst we ld mu br  ctl       fwd    pst pfl
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 0, 0);   // s0 reset
        // forward M then WB
        step(0, 1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 5'b00000, 4'h0, 0, 0);   // s1 producer r3
        step(0, 1, 0, 3, 2'b01, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 0, 0);   // s2 reader r3
        step(0, 1, 0, 3, 2'b01, 0, 0, 0, 0, 0, 5'b00000, 4'b0010, 0, 0); // s3 M fwd
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'b0001, 0, 0); // s4 WB fwd
        // load-use on operand 1
        step(0, 1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 5'b00000, 4'h0, 0, 0);   // s5 load r5
        step(0, 1, 5, 0, 2'b10, 0, 0, 0, 0, 0, 5'b11010, 4'h0, 0, 0);   // s6 stall
        step(0, 1, 5, 0, 2'b10, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 1, 0);   // s7 replay
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'b0100, 1, 0); // s8 WB fwd op1
        // load-use together with taken branch
        step(0, 1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 5'b00000, 4'h0, 1, 0);   // s9 load r5
        step(0, 1, 5, 0, 2'b10, 0, 0, 0, 0, 1, 5'b00110, 4'h0, 1, 0);   // s10 branch wins
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 1, 1);   // s11 bubble
        // multi-cycle op reading r2 from a preceding producer
        step(0, 1, 0, 0, 2'b00, 2, 1, 0, 0, 0, 5'b00000, 4'h0, 1, 1);   // s12 producer r2
        step(0, 1, 0, 2, 2'b01, 7, 1, 0, 1, 0, 5'b00000, 4'h0, 1, 1);   // s13 multi
        step(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b11001, 4'b0010, 1, 1); // s14 hold 1
        step(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b11001, 4'b0001, 2, 1); // s15 hold 2, M bubbled
        step(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 3, 1);   // s16 released
        // reset during the first EX_MULTI cycle
        step(0, 1, 0, 0, 2'b00, 8, 1, 0, 1, 0, 5'b00000, 4'h0, 3, 1);   // s17 multi
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 3, 1);   // s18 reset
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 0, 0);   // s19 aborted
        step(0, 1, 0, 0, 2'b00, 8, 1, 0, 1, 0, 5'b00000, 4'h0, 0, 0);   // s20 multi again
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b11001, 4'h0, 0, 0);   // s21 hold 1
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b11001, 4'h0, 1, 0);   // s22 hold 2
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 2, 0);   // s23 released
        // M beats WB when both write the same register
        step(0, 1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 5'b00000, 4'h0, 2, 0);   // s24 producer A r4
        step(0, 1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 5'b00000, 4'h0, 2, 0);   // s25 producer B r4
        step(0, 1, 4, 4, 2'b11, 0, 0, 0, 0, 0, 5'b00000, 4'h0, 2, 0);   // s26 reader r4,r4
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 5'b00000, 4'b1010, 2, 0); // s27 both from M

        @(negedge clock);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
